// File: rtl/ctrl_mc.sv
// ctrl_mc -- multi-cycle control unit for the MIPS datapath.
//
// Steps each instruction through IF/ID/EX/MEM/WB, stalling in IF and MEM
// until the shared memory port raises mem_ready.  A watchdog traps a bus
// that never answers; an undecodable opcode traps as illegal.  Both traps
// are sticky until rst.  instret counts retired instructions.
//
// Parameters
//   TIMEOUT  consecutive mem_ready-low cycles in IF/MEM before bus error (0 = off)
//   CNT_W    width of the retired-instruction counter
// Ports
//   clk, rst            clock, synchronous active-high reset
//   Op, Funct           instruction fields from the IR (stable from ID to retire)
//   Zero                ALU zero flag, used in EX only
//   mem_ready           memory completes the current request this cycle
//   PCWrite, IRWrite    PC / IR load enables
//   MemRead, MemWrite   memory requests, held for the whole wait
//   RegWrite            register file write enable
//   EXTOp, ALUSrc       sign-extend immediate / ALU B operand is immediate
//   ALUOp, NPCOp        ALU operation / next-PC source
//   GPRSel, WDSel       write register select / write data select
//   state               current FSM state (debug)
//   illegal, bus_err    sticky trap causes
//   instret             retired-instruction count (wraps)
module ctrl_mc #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             EXTOp,
    output logic             ALUSrc,
    output logic [3:0]       ALUOp,
    output logic [3:0]       NPCOp,
    output logic [1:0]       GPRSel,
    output logic [1:0]       WDSel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SLLV = 4'd11;

    localparam logic [3:0] NPC_PLUS4  = 4'd0;
    localparam logic [3:0] NPC_BRANCH = 4'd1;
    localparam logic [3:0] NPC_JUMP   = 4'd2;
    localparam logic [3:0] NPC_JR     = 4'd3;
    localparam logic [3:0] NPC_JALR   = 4'd4;

    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_31 = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    state_t          st;
    state_t          st_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_nxt;
    logic            wd_expire;
    logic            waiting;
    logic            retire;

    // Instruction decode
    logic       d_valid;
    logic [3:0] d_alu;
    logic       d_src;
    logic       d_ext;
    logic       is_rtype;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;

    always_comb begin
        d_valid = 1'b1;
        d_alu   = ALU_NOP;
        d_src   = 1'b0;
        d_ext   = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_jal  = 1'b0;
        is_jr   = 1'b0;
        is_jalr = 1'b0;
        is_rtype = (Op == 6'h00);
        case (Op)
            6'h00: begin
                case (Funct)
                    6'h20, 6'h21: d_alu = ALU_ADD;
                    6'h22, 6'h23: d_alu = ALU_SUB;
                    6'h24:        d_alu = ALU_AND;
                    6'h25:        d_alu = ALU_OR;
                    6'h27:        d_alu = ALU_NOR;
                    6'h2A:        d_alu = ALU_SLT;
                    6'h2B:        d_alu = ALU_SLTU;
                    6'h00:        d_alu = ALU_SLL;
                    6'h02:        d_alu = ALU_SRL;
                    6'h04:        d_alu = ALU_SLLV;
                    6'h08:        is_jr = 1'b1;
                    6'h09:        is_jalr = 1'b1;
                    default:      d_valid = 1'b0;
                endcase
            end
            6'h08: begin d_alu = ALU_ADD; d_src = 1'b1; d_ext = 1'b1; end  // addi
            6'h0D: begin d_alu = ALU_OR;  d_src = 1'b1; end                // ori
            6'h0C: begin d_alu = ALU_AND; d_src = 1'b1; end                // andi
            6'h0F: begin d_alu = ALU_LUI; d_src = 1'b1; end                // lui
            6'h0A: begin d_alu = ALU_SLT; d_src = 1'b1; d_ext = 1'b1; end  // slti
            6'h23: begin d_alu = ALU_ADD; d_src = 1'b1; d_ext = 1'b1; is_lw = 1'b1; end
            6'h2B: begin d_alu = ALU_ADD; d_src = 1'b1; d_ext = 1'b1; is_sw = 1'b1; end
            6'h04: begin d_alu = ALU_SUB; d_ext = 1'b1; is_beq = 1'b1; end
            6'h05: begin d_alu = ALU_SUB; d_ext = 1'b1; is_bne = 1'b1; end
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            default: d_valid = 1'b0;
        endcase
    end

    // Watchdog: counts consecutive stalled cycles; any handshake or state
    // change restarts it.  A handshake on the last allowed cycle still wins.
    always_comb begin
        waiting   = ((st == S_IF) || (st == S_MEM)) && !mem_ready;
        wd_expire = waiting && (TIMEOUT != 0) && (wd_cnt == WD_LAST);
        wd_nxt    = (waiting && !wd_expire) ? wd_cnt + 1'b1 : '0;
    end

    // Next state, retire strobe and Moore/handshake-qualified outputs
    always_comb begin
        st_nxt   = st;
        retire   = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        EXTOp    = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_PLUS4;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        case (st)
            S_IF: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    st_nxt  = S_ID;
                end else if (wd_expire) begin
                    st_nxt = S_TRAP;
                end
            end
            S_ID: st_nxt = d_valid ? S_EX : S_TRAP;
            S_EX: begin
                ALUOp  = d_alu;
                ALUSrc = d_src;
                EXTOp  = d_ext;
                if (is_beq || is_bne) begin
                    PCWrite = (is_beq && Zero) || (is_bne && !Zero);
                    NPCOp   = NPC_BRANCH;
                end else if (is_j) begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JUMP;
                end else if (is_jr) begin
                    PCWrite = 1'b1;
                    NPCOp   = NPC_JR;
                end else if (is_jal) begin
                    PCWrite  = 1'b1;
                    NPCOp    = NPC_JUMP;
                    RegWrite = 1'b1;
                    GPRSel   = GPR_31;
                    WDSel    = WD_PC;
                end else if (is_jalr) begin
                    PCWrite  = 1'b1;
                    NPCOp    = NPC_JALR;
                    RegWrite = 1'b1;
                    GPRSel   = GPR_RD;
                    WDSel    = WD_PC;
                end
                if (is_beq || is_bne || is_j || is_jr || is_jal || is_jalr) begin
                    st_nxt = S_IF;
                    retire = 1'b1;
                end else if (is_lw || is_sw) begin
                    st_nxt = S_MEM;
                end else begin
                    st_nxt = S_WB;
                end
            end
            S_MEM: begin
                ALUOp    = d_alu;
                ALUSrc   = d_src;
                EXTOp    = d_ext;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        st_nxt = S_WB;
                    end else begin
                        st_nxt = S_IF;
                        retire = 1'b1;
                    end
                end else if (wd_expire) begin
                    st_nxt = S_TRAP;
                end
            end
            S_WB: begin
                ALUOp    = d_alu;
                ALUSrc   = d_src;
                EXTOp    = d_ext;
                RegWrite = 1'b1;
                GPRSel   = is_rtype ? GPR_RD : GPR_RT;
                WDSel    = is_lw ? WD_MEM : WD_ALU;
                st_nxt   = S_IF;
                retire   = 1'b1;
            end
            S_TRAP: st_nxt = S_TRAP;
            default: st_nxt = S_IF;
        endcase
        // No memory or register side effect may escape during reset.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IF;
            wd_cnt  <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
            instret <= '0;
        end else begin
            st     <= st_nxt;
            wd_cnt <= wd_nxt;
            if (retire) instret <= instret + 1'b1;
            if ((st == S_ID) && !d_valid) illegal <= 1'b1;
            if (wd_expire) bus_err <= 1'b1;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_ctrl_mc.sv
module tb_ctrl_mc;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    Op, Funct;
    logic          Zero, mem_ready;
    logic          PCWrite, IRWrite, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc;
    logic [3:0]    ALUOp, NPCOp;
    logic [1:0]    GPRSel, WDSel;
    logic [2:0]    state;
    logic          illegal, bus_err;
    logic [CW-1:0] instret;

    ctrl_mc #(.TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .illegal(illegal),
        .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          pcw, irw, mrd, mwr, rgw, ext, src;
        logic [3:0]    alu, npc;
        logic [1:0]    gpr, wds;
        logic          ill, berr;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t obs;
    assign obs = {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, EXTOp,
                  ALUSrc, ALUOp, NPCOp, GPRSel, WDSel, illegal, bus_err, instret};

    // Instruction table: encoding plus the architectural effect of each instruction.
    localparam logic [3:0] K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4,
                           K_J = 5, K_JAL = 6, K_JR = 7, K_JALR = 8;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        logic       src;
        logic       ext;
        logic [3:0] kind;
    } ent_t;

    function automatic ent_t ent(input int i);
        case (i)
            0:  return {6'h00, 6'h20, 4'd1,  1'b0, 1'b0, K_ALU};  // add
            1:  return {6'h00, 6'h21, 4'd1,  1'b0, 1'b0, K_ALU};  // addu
            2:  return {6'h00, 6'h22, 4'd2,  1'b0, 1'b0, K_ALU};  // sub
            3:  return {6'h00, 6'h23, 4'd2,  1'b0, 1'b0, K_ALU};  // subu
            4:  return {6'h00, 6'h24, 4'd3,  1'b0, 1'b0, K_ALU};  // and
            5:  return {6'h00, 6'h25, 4'd4,  1'b0, 1'b0, K_ALU};  // or
            6:  return {6'h00, 6'h27, 4'd8,  1'b0, 1'b0, K_ALU};  // nor
            7:  return {6'h00, 6'h2A, 4'd5,  1'b0, 1'b0, K_ALU};  // slt
            8:  return {6'h00, 6'h2B, 4'd6,  1'b0, 1'b0, K_ALU};  // sltu
            9:  return {6'h00, 6'h00, 4'd7,  1'b0, 1'b0, K_ALU};  // sll
            10: return {6'h00, 6'h02, 4'd10, 1'b0, 1'b0, K_ALU};  // srl
            11: return {6'h00, 6'h04, 4'd11, 1'b0, 1'b0, K_ALU};  // sllv
            12: return {6'h00, 6'h08, 4'd0,  1'b0, 1'b0, K_JR};   // jr
            13: return {6'h00, 6'h09, 4'd0,  1'b0, 1'b0, K_JALR}; // jalr
            14: return {6'h08, 6'h00, 4'd1,  1'b1, 1'b1, K_ALU};  // addi
            15: return {6'h0D, 6'h00, 4'd4,  1'b1, 1'b0, K_ALU};  // ori
            16: return {6'h23, 6'h00, 4'd1,  1'b1, 1'b1, K_LW};   // lw
            17: return {6'h2B, 6'h00, 4'd1,  1'b1, 1'b1, K_SW};   // sw
            18: return {6'h04, 6'h00, 4'd2,  1'b0, 1'b1, K_BEQ};  // beq
            19: return {6'h05, 6'h00, 4'd2,  1'b0, 1'b1, K_BNE};  // bne
            20: return {6'h0F, 6'h00, 4'd9,  1'b1, 1'b0, K_ALU};  // lui
            21: return {6'h0A, 6'h00, 4'd5,  1'b1, 1'b1, K_ALU};  // slti
            22: return {6'h0C, 6'h00, 4'd3,  1'b1, 1'b0, K_ALU};  // andi
            23: return {6'h02, 6'h00, 4'd0,  1'b0, 1'b0, K_J};    // j
            default: return {6'h03, 6'h00, 4'd0, 1'b0, 1'b0, K_JAL}; // jal
        endcase
    endfunction

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] m_cnt;
    logic          m_ill, m_berr;

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs, compare every output at the falling edge.
    task automatic cyc(input logic mr, input logic z, input obs_t e_in, input string tag);
        obs_t e;
        e      = e_in;
        e.ill  = m_ill;
        e.berr = m_berr;
        e.cnt  = m_cnt;
        mem_ready = mr;
        Zero      = z;
        @(negedge clk);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(input logic [2:0] st);
        obs_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    task automatic do_reset(input obs_t held, input string tag);
        rst = 1'b1;
        cyc(rnd1(), rnd1(), held, tag);
        m_cnt  = '0;
        m_ill  = 1'b0;
        m_berr = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic fetch(input int if_w);
        obs_t e;
        Op    = 6'($urandom);
        Funct = 6'($urandom);
        for (int i = 0; i < if_w; i++) begin
            e = mk(3'd0); e.mrd = 1'b1;
            cyc(1'b0, rnd1(), e, "if_wait");
        end
        e = mk(3'd0); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        cyc(1'b1, rnd1(), e, "if_fetch");
    endtask

    // Reference: the full cycle-by-cycle trace of one legal instruction.
    task automatic run_idx(input int idx, input logic z, input int if_w, input int mem_w);
        ent_t t;
        obs_t e;
        t = ent(idx);
        fetch(if_w);
        Op    = t.op;
        Funct = (t.op == 6'h00) ? t.fn : 6'($urandom);
        cyc(rnd1(), rnd1(), mk(3'd1), "id");
        e = mk(3'd2); e.alu = t.alu; e.src = t.src; e.ext = t.ext;
        case (t.kind)
            K_BEQ:  begin e.pcw = z;  e.npc = 4'd1; end
            K_BNE:  begin e.pcw = !z; e.npc = 4'd1; end
            K_J:    begin e.pcw = 1'b1; e.npc = 4'd2; end
            K_JR:   begin e.pcw = 1'b1; e.npc = 4'd3; end
            K_JAL:  begin e.pcw = 1'b1; e.npc = 4'd2; e.rgw = 1'b1; e.gpr = 2'b10; e.wds = 2'b10; end
            K_JALR: begin e.pcw = 1'b1; e.npc = 4'd4; e.rgw = 1'b1; e.gpr = 2'b00; e.wds = 2'b10; end
            default: ;
        endcase
        cyc(rnd1(), z, e, "ex");
        if (t.kind >= K_BEQ) begin
            m_cnt = m_cnt + 1'b1;
            return;
        end
        if (t.kind == K_LW || t.kind == K_SW) begin
            e = mk(3'd3); e.alu = t.alu; e.src = t.src; e.ext = t.ext;
            e.mrd = (t.kind == K_LW); e.mwr = (t.kind == K_SW);
            for (int i = 0; i < mem_w; i++) cyc(1'b0, rnd1(), e, "mem_wait");
            cyc(1'b1, rnd1(), e, "mem_done");
            if (t.kind == K_SW) begin
                m_cnt = m_cnt + 1'b1;
                return;
            end
        end
        e = mk(3'd4); e.alu = t.alu; e.src = t.src; e.ext = t.ext; e.rgw = 1'b1;
        e.gpr = (t.op == 6'h00) ? 2'b00 : 2'b01;
        e.wds = (t.kind == K_LW) ? 2'b01 : 2'b00;
        cyc(rnd1(), rnd1(), e, "wb");
        m_cnt = m_cnt + 1'b1;
    endtask

    task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
        fetch(0);
        Op = op; Funct = fn;
        cyc(rnd1(), rnd1(), mk(3'd1), "ill_id");
        m_ill = 1'b1;
        for (int i = 0; i < 20; i++) cyc(rnd1(), rnd1(), mk(3'd5), "ill_trap");
        do_reset(mk(3'd5), "ill_rst");
    endtask

    initial begin
        obs_t e;
        rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0; Op = '0; Funct = '0;
        m_cnt = '0; m_ill = 1'b0; m_berr = 1'b0;
        @(posedge clk); #1;
        cyc(1'b1, 1'b0, mk(3'd0), "reset0");
        cyc(1'b0, 1'b1, mk(3'd0), "reset1");
        rst = 1'b0;

        // Directed cases
        run_idx(1, 1'b0, 0, 0);   // addu $3,$1,$2
        run_idx(16, 1'b0, 0, 2);  // lw, two MEM wait cycles
        run_idx(18, 1'b1, 0, 0);  // beq taken
        run_idx(18, 1'b0, 0, 0);  // beq not taken
        run_idx(24, 1'b0, 0, 0);  // jal
        run_idx(17, 1'b0, 3, 3);  // sw, handshake on the last allowed wait cycle

        // Random instruction mix; instret wraps past 2^CW
        for (int n = 0; n < 40; n++)
            run_idx($urandom_range(0, 24), rnd1(), $urandom_range(0, 3), $urandom_range(0, 3));

        // Illegal opcode and illegal R-type funct
        run_illegal(6'h3F, 6'h00);
        run_illegal(6'h00, 6'h01);

        // rst during a sw MEM wait
        fetch(0);
        Op = 6'h2B;
        cyc(1'b1, 1'b0, mk(3'd1), "sw_id");
        e = mk(3'd2); e.alu = 4'd1; e.src = 1'b1; e.ext = 1'b1;
        cyc(1'b0, 1'b0, e, "sw_ex");
        e.st = 3'd3; e.mwr = 1'b1;
        cyc(1'b0, 1'b0, e, "sw_mem");
        e.mwr = 1'b0;
        do_reset(e, "sw_rst");
        run_idx(1, 1'b0, 1, 0);

        // Watchdog in IF
        do_reset(mk(3'd0), "pre_wd_if");
        for (int i = 0; i < 4; i++) begin
            e = mk(3'd0); e.mrd = 1'b1;
            cyc(1'b0, rnd1(), e, "wd_if_wait");
        end
        m_berr = 1'b1;
        for (int i = 0; i < 3; i++) cyc(rnd1(), rnd1(), mk(3'd5), "wd_if_trap");
        do_reset(mk(3'd5), "wd_if_rst");

        // Watchdog in MEM
        fetch(0);
        Op = 6'h23;
        cyc(1'b0, 1'b0, mk(3'd1), "wd_mem_id");
        e = mk(3'd2); e.alu = 4'd1; e.src = 1'b1; e.ext = 1'b1;
        cyc(1'b0, 1'b0, e, "wd_mem_ex");
        e.st = 3'd3; e.mrd = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, rnd1(), e, "wd_mem_wait");
        m_berr = 1'b1;
        for (int i = 0; i < 3; i++) cyc(rnd1(), rnd1(), mk(3'd5), "wd_mem_trap");
        do_reset(mk(3'd5), "wd_mem_rst");
        run_idx(14, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
